// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// requester port indices and timeout counter sizing.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant decision. Holds the index of the last
// winner and, on contention, favours the other port.
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt,
    output logic       o_idx,
    output logic       o_valid
);

    logic r_last;
    logic w_idx;

    // Resetting r_last to 1 makes port 0 the first winner under contention.
    always_comb begin
        w_idx = 1'b0;
        if (i_req == 2'b11) begin
            w_idx = ~r_last;
        end else if (i_req[1]) begin
            w_idx = 1'b1;
        end
    end

    assign o_valid = |i_req;
    assign o_idx   = w_idx;
    assign o_gnt   = o_valid ? (w_idx ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (i_update && o_valid) begin
            r_last <= w_idx;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one req/gnt/rvalid data-memory port between the core Memory stage
// (port 0) and a DMA master (port 1); one outstanding transaction with timeout.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req0_i,
    input  logic                req1_i,
    input  logic                we0_i,
    input  logic                we1_i,
    input  logic [ADDR_W-1:0]   addr0_i,
    input  logic [ADDR_W-1:0]   addr1_i,
    input  logic [DATA_W-1:0]   wdata0_i,
    input  logic [DATA_W-1:0]   wdata1_i,
    input  logic [DATA_W/8-1:0] be0_i,
    input  logic [DATA_W/8-1:0] be1_i,
    output logic                gnt0_o,
    output logic                gnt1_o,
    output logic                rvalid0_o,
    output logic                rvalid1_o,
    output logic [DATA_W-1:0]   rdata0_o,
    output logic [DATA_W-1:0]   rdata1_o,
    output logic                err0_o,
    output logic                err1_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = 1;

    arb_state_e        r_state;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_err0;
    logic              r_err1;

    logic              w_idle;
    logic              w_busy;
    logic [1:0]        w_arbGnt;
    logic              w_arbIdx;
    logic              w_arbValid;
    logic [CNT_W-1:0]  w_cntNext;
    logic              w_complete;
    logic              w_timeout;
    logic              w_done;

    assign w_idle = (r_state == ST_IDLE);
    assign w_busy = (r_state == ST_ADDR) || (r_state == ST_DATA);

    rr_arbiter2 u_rr (
        .i_clk    (clk_i),
        .i_rst_n  (rst_i),
        .i_req    ({req1_i, req0_i}),
        .i_update (w_idle),
        .o_gnt    (w_arbGnt),
        .o_idx    (w_arbIdx),
        .o_valid  (w_arbValid)
    );

    // Grants are combinational but must read 0 while reset is held.
    assign gnt0_o = w_idle & w_arbGnt[0] & rst_i;
    assign gnt1_o = w_idle & w_arbGnt[1] & rst_i;

    // A response only counts once the memory has accepted the address,
    // either earlier (DATA) or in this very cycle (ADDR with gnt).
    assign w_cntNext  = r_cnt + CNT_ONE;
    assign w_complete = mem_rvalid_i &&
                        ((r_state == ST_DATA) || ((r_state == ST_ADDR) && mem_gnt_i));
    assign w_timeout  = w_busy && !w_complete && (w_cntNext == TIMEOUT_CNT);
    assign w_done     = w_complete || w_timeout;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_owner <= PORT_CORE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_arbValid) begin
                        r_owner <= w_arbIdx;
                        r_we    <= w_arbIdx ? we1_i    : we0_i;
                        r_addr  <= w_arbIdx ? addr1_i  : addr0_i;
                        r_wdata <= w_arbIdx ? wdata1_i : wdata0_i;
                        r_be    <= w_arbIdx ? be1_i    : be0_i;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_cnt <= w_cntNext;
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end else if (mem_gnt_i) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    r_cnt <= w_cntNext;
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Writes and timeouts return zero data; the non-owner port stays quiet.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            r_rvalid0 <= w_done && (r_owner == PORT_CORE);
            r_rvalid1 <= w_done && (r_owner == PORT_DMA);
            r_rdata0  <= (w_complete && !r_we && (r_owner == PORT_CORE)) ? mem_rdata_i : '0;
            r_rdata1  <= (w_complete && !r_we && (r_owner == PORT_DMA))  ? mem_rdata_i : '0;
            r_err0    <= w_timeout && (r_owner == PORT_CORE);
            r_err1    <= w_timeout && (r_owner == PORT_DMA);
        end
    end

    assign rvalid0_o   = r_rvalid0;
    assign rvalid1_o   = r_rvalid1;
    assign rdata0_o    = r_rdata0;
    assign rdata1_o    = r_rdata1;
    assign err0_o      = r_err0;
    assign err1_o      = r_err1;

    assign mem_req_o   = (r_state == ST_ADDR);
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_be_o    = r_be;

    // Requesters must hold req until granted.
    a_req0Held: assert property (@(posedge clk_i) disable iff (!rst_i)
                                 (req0_i && !gnt0_o) |=> req0_i);
    a_req1Held: assert property (@(posedge clk_i) disable iff (!rst_i)
                                 (req1_i && !gnt1_o) |=> req1_i);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_dmem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req0_i, req1_i, we0_i, we1_i;
    logic [AW-1:0] addr0_i, addr1_i;
    logic [DW-1:0] wdata0_i, wdata1_i;
    logic [BW-1:0] be0_i, be1_i;
    logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, err0_o, err1_o;
    logic [DW-1:0] rdata0_o, rdata1_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [BW-1:0] mem_be_o;
    logic          mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req0_i      (req0_i),
        .req1_i      (req1_i),
        .we0_i       (we0_i),
        .we1_i       (we1_i),
        .addr0_i     (addr0_i),
        .addr1_i     (addr1_i),
        .wdata0_i    (wdata0_i),
        .wdata1_i    (wdata1_i),
        .be0_i       (be0_i),
        .be1_i       (be1_i),
        .gnt0_o      (gnt0_o),
        .gnt1_o      (gnt1_o),
        .rvalid0_o   (rvalid0_o),
        .rvalid1_o   (rvalid1_o),
        .rdata0_o    (rdata0_o),
        .rdata1_o    (rdata1_o),
        .err0_o      (err0_o),
        .err1_o      (err1_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h",
                     name, $time, actual, expected);
        end
    endtask

    // Reference model: one transaction record, its age in cycles since the
    // address went out, and a response scheduled for the following cycle.
    bit          mBusy, mOwner, mAccepted, mLast, mWe;
    int          mAge;
    logic [31:0] mAddr, mWdata;
    logic [3:0]  mBe;
    bit          pValid, pOwner, pErr;
    logic [31:0] pData;
    bit          eG0, eG1, eReq, eRv0, eRv1, winner;

    always @(negedge clk) begin
        if (!rst_i) begin
            mBusy = 0; mLast = 1; mAccepted = 0; mAge = 0; pValid = 0;
            checkOutput("rstCtl", {24'd0, gnt0_o, gnt1_o, rvalid0_o, rvalid1_o,
                                   err0_o, err1_o, mem_req_o, mem_we_o}, 32'd0);
            checkOutput("rstRdata", rdata0_o | rdata1_o, 32'd0);
            checkOutput("rstMemBus", mem_addr_o | mem_wdata_o | {28'd0, mem_be_o}, 32'd0);
        end else begin
            eRv0 = pValid && !pOwner;
            eRv1 = pValid && pOwner;
            checkOutput("rvalid0", rvalid0_o, eRv0);
            checkOutput("rvalid1", rvalid1_o, eRv1);
            checkOutput("rdata0", rdata0_o, eRv0 ? pData : 32'd0);
            checkOutput("rdata1", rdata1_o, eRv1 ? pData : 32'd0);
            checkOutput("err0", err0_o, eRv0 ? pErr : 1'b0);
            checkOutput("err1", err1_o, eRv1 ? pErr : 1'b0);
            pValid = 0;
            eG0 = 0; eG1 = 0; eReq = 0;
            if (!mBusy) begin
                if (req0_i || req1_i) begin
                    winner = (req0_i && req1_i) ? !mLast : req1_i;
                    eG0 = !winner; eG1 = winner;
                    mLast = winner; mOwner = winner; mBusy = 1;
                    mAccepted = 0; mAge = 0;
                    mWe    = winner ? we1_i    : we0_i;
                    mAddr  = winner ? addr1_i  : addr0_i;
                    mWdata = winner ? wdata1_i : wdata0_i;
                    mBe    = winner ? be1_i    : be0_i;
                end
            end else begin
                eReq = !mAccepted;
                mAge++;
                if (mem_rvalid_i && (mAccepted || mem_gnt_i)) begin
                    pValid = 1; pOwner = mOwner; pErr = 0;
                    pData = mWe ? 32'd0 : mem_rdata_i;
                    mBusy = 0;
                end else if (mAge == TMO) begin
                    pValid = 1; pOwner = mOwner; pErr = 1; pData = 32'd0;
                    mBusy = 0;
                end else if (mem_gnt_i) begin
                    mAccepted = 1;
                end
            end
            checkOutput("gnt0", gnt0_o, eG0);
            checkOutput("gnt1", gnt1_o, eG1);
            checkOutput("memReq", mem_req_o, eReq);
            if (eReq) begin
                checkOutput("memWe", mem_we_o, mWe);
                checkOutput("memAddr", mem_addr_o, mAddr);
                checkOutput("memWdata", mem_wdata_o, mWdata);
                checkOutput("memBe", mem_be_o, mBe);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    // Requesters only change their request once the previous one was granted.
    task automatic applyStimulus(input bit g0, input bit g1, input int gntPct, input int rvPct);
        if (!req0_i || g0) begin
            req0_i   = ($urandom_range(99) < 50);
            we0_i    = 1'($urandom_range(1));
            addr0_i  = $urandom;
            wdata0_i = $urandom;
            be0_i    = 4'($urandom_range(15));
        end
        if (!req1_i || g1) begin
            req1_i   = ($urandom_range(99) < 50);
            we1_i    = 1'($urandom_range(1));
            addr1_i  = $urandom;
            wdata1_i = $urandom;
            be1_i    = 4'($urandom_range(15));
        end
        mem_gnt_i    = ($urandom_range(99) < gntPct);
        mem_rvalid_i = ($urandom_range(99) < rvPct);
        mem_rdata_i  = $urandom;
    endtask

    task automatic testSingleRead();
        tick();
        req0_i = 1; we0_i = 0; addr0_i = 32'h100; be0_i = 4'hF; wdata0_i = 0;
        @(negedge clk); checkOutput("t1Gnt0", gnt0_o, 1);
        tick();
        req0_i = 0; mem_gnt_i = 1;
        @(negedge clk);
        checkOutput("t1MemReq", mem_req_o, 1);
        checkOutput("t1MemAddr", mem_addr_o, 32'h100);
        tick();
        mem_gnt_i = 0;
        @(negedge clk); checkOutput("t1ReqDrop", mem_req_o, 0);
        tick();
        mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D;
        tick();
        mem_rvalid_i = 0; mem_rdata_i = 0;
        @(negedge clk);
        checkOutput("t1Rvalid0", rvalid0_o, 1);
        checkOutput("t1Rdata0", rdata0_o, 32'hCAFEF00D);
        checkOutput("t1Err0", err0_o, 0);
        checkOutput("t1Rvalid1", rvalid1_o, 0);
    endtask

    task automatic testContention();
        int gntSeq[$];
        logic [31:0] addrSeq[$];
        bit g0, g1;
        doReset();
        req0_i = 1; we0_i = 0; addr0_i = 32'h1000;
        req1_i = 1; we1_i = 0; addr1_i = 32'h2000;
        mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h55AA55AA;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt0_o) gntSeq.push_back(0);
            if (gnt1_o) gntSeq.push_back(1);
            if (mem_req_o) addrSeq.push_back(mem_addr_o);
            tick();
        end
        checkOutput("t2GrantCount", (gntSeq.size() >= 4) ? 1 : 0, 1);
        checkOutput("t2AddrCount", (addrSeq.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < gntSeq.size()) checkOutput($sformatf("t2Grant%0d", i), gntSeq[i], i % 2);
            if (i < addrSeq.size())
                checkOutput($sformatf("t2Addr%0d", i), addrSeq[i],
                            (i % 2) ? 32'h2000 : 32'h1000);
        end
        for (int c = 0; c < 20 && (req0_i || req1_i); c++) begin
            @(negedge clk);
            g0 = gnt0_o; g1 = gnt1_o;
            tick();
            if (g0) req0_i = 0;
            if (g1) req1_i = 0;
        end
        checkOutput("t2Drained", {30'd0, req1_i, req0_i}, 0);
        repeat (3) tick();
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    endtask

    task automatic testDmaWrite();
        tick();
        req1_i = 1; we1_i = 1; be1_i = 4'b0011; wdata1_i = 32'h12345678; addr1_i = 32'h2000;
        @(negedge clk); checkOutput("t3Gnt1", gnt1_o, 1);
        tick();
        req1_i = 0; mem_gnt_i = 1;
        @(negedge clk);
        checkOutput("t3MemWe", mem_we_o, 1);
        checkOutput("t3MemBe", mem_be_o, 4'b0011);
        checkOutput("t3MemWdata", mem_wdata_o, 32'h12345678);
        checkOutput("t3MemAddr", mem_addr_o, 32'h2000);
        tick();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        tick();
        mem_rvalid_i = 0; mem_rdata_i = 0;
        @(negedge clk);
        checkOutput("t3Rvalid1", rvalid1_o, 1);
        checkOutput("t3Rdata1", rdata1_o, 0);
        checkOutput("t3Rvalid0", rvalid0_o, 0);
    endtask

    task automatic testGntStall();
        tick();
        req0_i = 1; we0_i = 0; addr0_i = 32'h300; be0_i = 4'hF;
        @(negedge clk); checkOutput("t4Gnt0", gnt0_o, 1);
        tick();
        req0_i = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t4StallReq%0d", i), mem_req_o, 1);
            checkOutput($sformatf("t4StallAddr%0d", i), mem_addr_o, 32'h300);
            tick();
        end
        mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hA5A50300;
        tick();
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        @(negedge clk);
        checkOutput("t4Rvalid0", rvalid0_o, 1);
        checkOutput("t4Rdata0", rdata0_o, 32'hA5A50300);
    endtask

    task automatic testTimeout();
        int lat;
        lat = -1;
        tick();
        req1_i = 1; we1_i = 0; addr1_i = 32'h400; be1_i = 4'hF;
        @(negedge clk); checkOutput("t5Gnt1", gnt1_o, 1);
        tick();
        req1_i = 0; mem_gnt_i = 1;
        tick();
        mem_gnt_i = 0;
        for (int c = 2; c < 30; c++) begin
            @(negedge clk);
            if (rvalid1_o) begin
                lat = c;
                break;
            end
            tick();
        end
        checkOutput("t5Latency", lat, TMO + 1);
        checkOutput("t5Err1", err1_o, 1);
        checkOutput("t5Rdata1", rdata1_o, 0);
        tick(); tick(); tick();
        mem_rvalid_i = 1; mem_rdata_i = 32'h0BADF00D;
        tick();
        mem_rvalid_i = 0; mem_rdata_i = 0;
        @(negedge clk);
        checkOutput("t5LateRv", {30'd0, rvalid1_o, rvalid0_o}, 0);
        checkOutput("t5LateReq", mem_req_o, 0);
    endtask

    task automatic testResetInData();
        bit got;
        got = 0;
        tick();
        req0_i = 1; we0_i = 0; addr0_i = 32'h500; be0_i = 4'hF;
        @(negedge clk); checkOutput("t6Gnt0", gnt0_o, 1);
        tick();
        req0_i = 0; mem_gnt_i = 1;
        tick();
        mem_gnt_i = 0;
        checkOutput("t6AddrBefore", mem_addr_o, 32'h500);
        #2 rst_i = 0;
        req0_i = 1; req1_i = 1; addr0_i = 32'h600; addr1_i = 32'h700; we1_i = 0;
        #1;
        checkOutput("t6AsyncAddr", mem_addr_o, 0);
        checkOutput("t6AsyncGnt", {30'd0, gnt1_o, gnt0_o}, 0);
        tick();
        rst_i = 1;
        @(negedge clk);
        checkOutput("t6FirstGnt0", gnt0_o, 1);
        checkOutput("t6FirstGnt1", gnt1_o, 0);
        tick();
        req0_i = 0; mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (gnt1_o) begin
                got = 1;
                break;
            end
            tick();
        end
        checkOutput("t6Gnt1Seen", got, 1);
        tick();
        req1_i = 0;
        repeat (3) tick();
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    endtask

    initial begin
        int gntPct[5] = '{70, 30, 80, 0, 100};
        int rvPct[5]  = '{70, 20, 0, 50, 100};
        bit g0, g1;
        rst_i = 0;
        req0_i = 0; req1_i = 0; we0_i = 0; we1_i = 0;
        addr0_i = 0; addr1_i = 0; wdata0_i = 0; wdata1_i = 0; be0_i = 0; be1_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1;

        testSingleRead();
        testContention();
        testDmaWrite();
        testGntStall();
        testTimeout();
        testResetInData();

        $display("[TB] random traffic phase");
        g0 = 0; g1 = 0;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 400; c++) begin
                tick();
                applyStimulus(g0, g1, gntPct[s], rvPct[s]);
                @(negedge clk);
                g0 = gnt0_o;
                g1 = gnt1_o;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
